id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding and load-use hazard unit; sits directly upstream of alu.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/id_ex_operand_stage_fwd_unit.sv | 45 ++++
 rtl/id_ex_operand_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU operation codes and the
// operand-forwarding source select used by the ID/EX operand stage.
package cpu_pkg;

  localparam int CPU_W   = 32;  // datapath width
  localparam int CPU_RW  = 5;   // register index width
  localparam int CPU_OPW = 4;   // ALU_operation width
  localparam int CPU_SHW = 5;   // shift amount width

  // ALU_operation encodings understood by the downstream alu.
  localparam logic [CPU_OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [CPU_OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [CPU_OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [CPU_OPW-1:0] ALU_SUB = 4'b0110;
  localparam logic [CPU_OPW-1:0] ALU_SLT = 4'b0111;
  localparam logic [CPU_OPW-1:0] ALU_NOR = 4'b1100;
  localparam logic [CPU_OPW-1:0] ALU_SH  = 4'b1101;

  // Where an EX operand comes from after hazard resolution.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// fwd_unit: picks one EX operand from the EX/MEM producer, the MEM/WB
// producer or the registered register-file value. The younger producer
// (EX/MEM) wins; register 0 is never forwarded.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int W  = CPU_W,
  parameter int RW = CPU_RW
) (
  input  logic [RW-1:0] src_idx,
  input  logic [W-1:0]  rf_data,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic [W-1:0]  mem_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd,
  input  logic [W-1:0]  wb_result,
  output logic [W-1:0]  fwd_data
);

  fwd_sel_e sel;

  // Select the youngest in-flight producer of src_idx.
  always_comb begin
    sel = FWD_RF;
    if (src_idx != '0) begin
      if (mem_reg_write && (mem_rd == src_idx)) begin
        sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == src_idx)) begin
        sel = FWD_WB;
      end
    end
  end

  // Operand mux driven by the select above.
  always_comb begin
    fwd_data = rf_data;
    case (sel)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding and
// hazard detection, feeding the alu.
// Build option OPSTAGE_FWD_EN: when defined, EX operands are forwarded from
// EX/MEM and MEM/WB and only load-use stalls (one cycle). When undefined,
// operands come straight from the registered RF reads and ID stalls while any
// in-flight producer (EX, MEM or WB) writes a register it reads.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int W   = CPU_W,
  parameter int RW  = CPU_RW,
  parameter int OPW = CPU_OPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [W-1:0]      id_rs_data,
  input  logic [W-1:0]      id_rt_data,
  input  logic [W-1:0]      id_imm,
  input  logic              id_alu_src_imm,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [OPW-1:0]    id_alu_op,
  input  logic [CPU_SHW-1:0] id_shamt,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [RW-1:0]     mem_rd,
  input  logic              mem_reg_write,
  input  logic [W-1:0]      mem_result,
  input  logic [RW-1:0]     wb_rd,
  input  logic              wb_reg_write,
  input  logic [W-1:0]      wb_result,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [W-1:0]      A,
  output logic [W-1:0]      B,
  output logic [OPW-1:0]    ALU_operation,
  output logic [CPU_SHW-1:0] shamt,
  output logic [W-1:0]      ex_rt_fwd,
  output logic [RW-1:0]     ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read
);

  // ID/EX register state
  logic              valid_q, valid_d;
  logic [W-1:0]      rs_data_q, rs_data_d;
  logic [W-1:0]      rt_data_q, rt_data_d;
  logic [W-1:0]      imm_q, imm_d;
  logic              alu_src_imm_q, alu_src_imm_d;
  logic [RW-1:0]     rs_q, rs_d;
  logic [RW-1:0]     rt_q, rt_d;
  logic [RW-1:0]     rd_q, rd_d;
  logic [OPW-1:0]    alu_op_q, alu_op_d;
  logic [CPU_SHW-1:0] shamt_q, shamt_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;

  logic              load_use;
  logic              dep_stall;
  logic [W-1:0]      opnd_rf  [2];
  logic [W-1:0]      opnd_fwd [2];

  // True when the instruction in ID reads register prd written by a producer.
  function automatic logic id_reads(input logic we, input logic [RW-1:0] prd,
                                    input logic v, input logic urs, input logic urt,
                                    input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    return we && (prd != '0) && v && ((urs && (rs == prd)) || (urt && (rt == prd)));
  endfunction

  // Hazard detection: a load in EX cannot forward its data in time for ID.
  always_comb begin
    load_use = id_reads(valid_q && mem_read_q, rd_q, id_valid,
                        id_uses_rs, id_uses_rt, id_rs, id_rt);
`ifdef OPSTAGE_FWD_EN
    dep_stall = 1'b0;
`else
    dep_stall = id_reads(valid_q && reg_write_q, rd_q, id_valid,
                         id_uses_rs, id_uses_rt, id_rs, id_rt)
             || id_reads(mem_reg_write, mem_rd, id_valid,
                         id_uses_rs, id_uses_rt, id_rs, id_rt)
             || id_reads(wb_reg_write, wb_rd, id_valid,
                         id_uses_rs, id_uses_rt, id_rs, id_rt);
`endif
    // A squash or reset makes holding ID pointless, so neither stalls.
    stall_out = !rst && !flush && (load_use || dep_stall);
  end

  // Next ID/EX contents: capture ID, or insert a bubble on flush/stall.
  always_comb begin
    valid_d       = id_valid;
    rs_data_d     = id_rs_data;
    rt_data_d     = id_rt_data;
    imm_d         = id_imm;
    alu_src_imm_d = id_alu_src_imm;
    rs_d          = id_rs;
    rt_d          = id_rt;
    rd_d          = id_rd;
    alu_op_d      = id_alu_op;
    shamt_d       = id_shamt;
    reg_write_d   = id_valid && id_reg_write;
    mem_read_d    = id_valid && id_mem_read;
    if (flush || stall_out) begin
      // Only the control bits matter for a bubble; datapath fields are don't-care.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end
  end

  // ID/EX pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
      alu_src_imm_q <= 1'b0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      alu_op_q      <= '0;
      shamt_q       <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      imm_q         <= imm_d;
      alu_src_imm_q <= alu_src_imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      alu_op_q      <= alu_op_d;
      shamt_q       <= shamt_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
    end
  end

  // Operand 0 is rs, operand 1 is rt.
  always_comb begin
    opnd_rf[0] = rs_data_q;
    opnd_rf[1] = rt_data_q;
  end

`ifdef OPSTAGE_FWD_EN
  logic [RW-1:0] opnd_idx [2];

  // Register indices the forwarding units compare against.
  always_comb begin
    opnd_idx[0] = rs_q;
    opnd_idx[1] = rt_q;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_unit #(
        .W  (W),
        .RW (RW)
      ) u_fwd (
        .src_idx       (opnd_idx[gi]),
        .rf_data       (opnd_rf[gi]),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .fwd_data      (opnd_fwd[gi])
      );
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nofwd
      assign opnd_fwd[gi] = opnd_rf[gi];
    end
  endgenerate
`endif

  // EX-side outputs toward the alu and the EX/MEM register.
  always_comb begin
    A             = opnd_fwd[0];
    ex_rt_fwd     = opnd_fwd[1];
    B             = alu_src_imm_q ? imm_q : opnd_fwd[1];
    ex_valid      = valid_q;
    ALU_operation = alu_op_q;
    shamt         = shamt_q;
    ex_rd         = rd_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage. The bench plays IF/ID, the register file
// (write-before-read), and the EX/MEM and MEM/WB stages. Its reference is an
// in-order architectural register model: an instruction entering EX must see
// the register values that sequential execution would give it.
module tb_id_ex_operand_stage;

  logic        clk, rst, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src_imm, id_uses_rs, id_uses_rt;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        stall_out, ex_valid;
  logic [31:0] A, B, ex_rt_fwd;
  logic [3:0]  ALU_operation;
  logic [4:0]  shamt, ex_rd;
  logic        ex_reg_write, ex_mem_read;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src_imm(id_alu_src_imm), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_alu_op(id_alu_op), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .stall_out(stall_out), .ex_valid(ex_valid), .A(A), .B(B),
    .ALU_operation(ALU_operation), .shamt(shamt), .ex_rt_fwd(ex_rt_fwd),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    int          tag;
    logic [4:0]  rs, rt, rd;
    bit          uses_rs, uses_rt, reg_write, mem_read, src_imm;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [31:0] result;
    logic [31:0] exp_a, exp_rt;
  } instr_t;

  instr_t      prog[$];
  int          pc;
  instr_t      ex_s, mem_s, wb_s;
  logic [31:0] rf   [32];
  logic [31:0] arch [32];
  int          vectors, miscompares;
  int          stall_cnt;
  bit          seen     [1024];
  logic [31:0] obs_a    [1024];
  logic [31:0] obs_b    [1024];
  logic        obs_stall[256];
  logic        obs_exv  [256];

  function automatic instr_t mk(input int tag, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input bit urs, input bit urt,
                                input bit rw, input bit mr, input bit simm,
                                input logic [31:0] imm, input logic [31:0] res);
    instr_t x;
    x.valid = 1'b1; x.tag = tag; x.rs = rs; x.rt = rt; x.rd = rd;
    x.uses_rs = urs; x.uses_rt = urt; x.reg_write = rw; x.mem_read = mr;
    x.src_imm = simm; x.imm = imm; x.result = res;
    x.op = 4'($urandom); x.sh = 5'($urandom);
    x.exp_a = '0; x.exp_rt = '0;
    return x;
  endfunction

  function automatic instr_t idle_slot();
    instr_t x;
    x = mk(0, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
    x.valid = 1'b0;
    return x;
  endfunction

  function automatic instr_t bubble();
    instr_t x;
    x = mk(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    x.valid = 1'b0;
    return x;
  endfunction

  // Register file read with write-before-read of the WB stage.
  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_s.valid && wb_s.reg_write && wb_s.rd == idx) return wb_s.result;
    return rf[idx];
  endfunction

  // Does in-flight producer p write a register that instruction c reads?
  function automatic bit depends(input instr_t p, input instr_t c);
    return p.valid && p.reg_write && p.rd != 5'd0 &&
           ((c.uses_rs && c.rs == p.rd) || (c.uses_rt && c.rt == p.rd));
  endfunction

  // One clock cycle: drive ID and downstream stages, check at negedge, advance model.
  task automatic cycle(input bit fl, input bit r, input int k);
    instr_t c;
    bit lu, dep, exp_stall, accept;
    if (pc < prog.size()) c = prog[pc]; else c = idle_slot();
    rst = r; flush = fl;
    id_valid = c.valid; id_rs = c.rs; id_rt = c.rt; id_rd = c.rd;
    id_uses_rs = c.uses_rs; id_uses_rt = c.uses_rt; id_reg_write = c.reg_write;
    id_mem_read = c.mem_read; id_alu_src_imm = c.src_imm; id_imm = c.imm;
    id_alu_op = c.op; id_shamt = c.sh;
    id_rs_data = rf_read(c.rs); id_rt_data = rf_read(c.rt);
    mem_rd = mem_s.rd; mem_reg_write = mem_s.valid && mem_s.reg_write;
    mem_result = mem_s.mem_read ? ~mem_s.result : mem_s.result;  // load data not ready in MEM
    wb_rd = wb_s.rd; wb_reg_write = wb_s.valid && wb_s.reg_write; wb_result = wb_s.result;

    lu = ex_s.valid && ex_s.mem_read && ex_s.rd != 5'd0 && c.valid &&
         ((c.uses_rs && c.rs == ex_s.rd) || (c.uses_rt && c.rt == ex_s.rd));
    dep = 1'b0;
`ifndef OPSTAGE_FWD_EN
    dep = c.valid && (depends(ex_s, c) || depends(mem_s, c) || depends(wb_s, c));
`endif
    exp_stall = !r && !fl && (lu || dep);

    @(negedge clk);
    if (k < 256) begin obs_stall[k] = stall_out; obs_exv[k] = ex_valid; end
    if (stall_out === 1'b1) stall_cnt++;
    vectors++;
    if (stall_out !== exp_stall) begin
      miscompares++; $display("FAIL stall_out cyc%0d: got %b expected %b", k, stall_out, exp_stall);
    end
    vectors++;
    if (ex_valid !== ex_s.valid) begin
      miscompares++; $display("FAIL ex_valid cyc%0d: got %b expected %b", k, ex_valid, ex_s.valid);
    end
    vectors++;
    if (ex_reg_write !== (ex_s.valid && ex_s.reg_write)) begin
      miscompares++; $display("FAIL ex_reg_write cyc%0d: got %b", k, ex_reg_write);
    end
    vectors++;
    if (ex_mem_read !== (ex_s.valid && ex_s.mem_read)) begin
      miscompares++; $display("FAIL ex_mem_read cyc%0d: got %b", k, ex_mem_read);
    end
    if (ex_s.valid) begin
      seen[ex_s.tag] = 1'b1; obs_a[ex_s.tag] = A; obs_b[ex_s.tag] = B;
      vectors++;
      if (ALU_operation !== ex_s.op || shamt !== ex_s.sh || ex_rd !== ex_s.rd) begin
        miscompares++;
        $display("FAIL ctrl tag%0d: got op=%h sh=%h rd=%0d expected op=%h sh=%h rd=%0d",
                 ex_s.tag, ALU_operation, shamt, ex_rd, ex_s.op, ex_s.sh, ex_s.rd);
      end
      if (ex_s.uses_rs) begin
        vectors++;
        if (A !== ex_s.exp_a) begin
          miscompares++; $display("FAIL A tag%0d: got %h expected %h", ex_s.tag, A, ex_s.exp_a);
        end
      end
      if (ex_s.uses_rt) begin
        vectors++;
        if (ex_rt_fwd !== ex_s.exp_rt) begin
          miscompares++;
          $display("FAIL ex_rt_fwd tag%0d: got %h expected %h", ex_s.tag, ex_rt_fwd, ex_s.exp_rt);
        end
      end
      if (ex_s.src_imm || ex_s.uses_rt) begin
        vectors++;
        if (B !== (ex_s.src_imm ? ex_s.imm : ex_s.exp_rt)) begin
          miscompares++;
          $display("FAIL B tag%0d: got %h expected %h", ex_s.tag, B,
                   ex_s.src_imm ? ex_s.imm : ex_s.exp_rt);
        end
      end
    end

    @(posedge clk);
    if (wb_s.valid && wb_s.reg_write && wb_s.rd != 5'd0) rf[wb_s.rd] = wb_s.result;
    wb_s = mem_s;
    mem_s = ex_s;
    accept = !r && c.valid && !fl && !exp_stall;
    if (accept) begin
      c.exp_a = arch[c.rs];
      c.exp_rt = arch[c.rt];
      ex_s = c;
      if (c.reg_write && c.rd != 5'd0) arch[c.rd] = c.result;
    end else begin
      ex_s = bubble();
    end
    if (!r && pc < prog.size() && (accept || fl || !c.valid)) pc++;
    #1;
  endtask

  // Run the loaded program until it has drained out of the pipeline.
  task automatic run_prog(input int flush_at, input int rst_at, input bit rand_flush);
    int k;
    bit fl;
    foreach (seen[i]) begin seen[i] = 1'b0; obs_a[i] = 'x; obs_b[i] = 'x; end
    foreach (obs_stall[i]) begin obs_stall[i] = 1'bx; obs_exv[i] = 1'bx; end
    stall_cnt = 0; pc = 0; k = 0;
    while ((pc < prog.size() || ex_s.valid || mem_s.valid || wb_s.valid) && k < 3000) begin
      fl = (k == flush_at) || (rand_flush && $urandom_range(0, 15) == 0);
      cycle(fl, k == rst_at, k);
      k++;
    end
    if (k >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d cycles required under 3000", k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1;
    id_rd = 5'd6; id_rs = 5'd6; id_uses_rs = 1'b1; id_alu_op = 4'hF;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
    vectors++;
    if (ALU_operation !== 4'b0000) begin miscompares++; $display("FAIL reset_alu_op: got %h expected 0", ALU_operation); end
    vectors++;
    if (stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
    vectors++;
    if (A !== 32'd0 || B !== 32'd0) begin miscompares++; $display("FAIL reset_AB: got %h/%h expected 0/0", A, B); end
    vectors++;
    if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got rw=%b mr=%b expected 0/0", ex_reg_write, ex_mem_read);
    end
    @(posedge clk); #1;
    ex_s = bubble(); mem_s = bubble(); wb_s = bubble();
  endtask

  task automatic test_mem_forward();
    logic [31:0] r1v;
    r1v = arch[1];
    prog.delete();
    prog.push_back(mk(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 32'd0, 32'h10));   // add r3,r1,r2
    prog.push_back(mk(2, 5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 0, 32'd0, 32'h77));   // sub r4,r3,r1
    run_prog(-1, -1, 1'b0);
    vectors++;
    if (obs_a[2] !== 32'h10) begin miscompares++; $display("FAIL mem_fwd_A: got %h expected 00000010", obs_a[2]); end
    vectors++;
    if (obs_b[2] !== r1v) begin miscompares++; $display("FAIL mem_fwd_B: got %h expected %h", obs_b[2], r1v); end
`ifdef OPSTAGE_FWD_EN
    vectors++;
    if (stall_cnt !== 0) begin miscompares++; $display("FAIL mem_fwd_stalls: got %0d expected 0", stall_cnt); end
`endif
  endtask

  task automatic test_mem_beats_wb();
    prog.delete();
    prog.push_back(mk(1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 0, 0, 32'd0, 32'h0000BBBB));
    prog.push_back(mk(2, 5'd2, 5'd1, 5'd5, 1, 1, 1, 0, 0, 32'd0, 32'h0000AAAA));
    prog.push_back(mk(3, 5'd5, 5'd1, 5'd9, 1, 0, 1, 0, 1, 32'h4, 32'h1));
    prog.push_back(mk(4, 5'd1, 5'd2, 5'd0, 1, 1, 1, 0, 0, 32'd0, 32'h1234));   // writes r0
    prog.push_back(mk(5, 5'd0, 5'd0, 5'd10, 1, 1, 1, 0, 0, 32'd0, 32'h2));
    run_prog(-1, -1, 1'b0);
    vectors++;
    if (obs_a[3] !== 32'h0000AAAA) begin miscompares++; $display("FAIL mem_over_wb: got %h expected 0000aaaa", obs_a[3]); end
    vectors++;
    if (obs_a[5] !== 32'd0 || obs_b[5] !== 32'd0) begin
      miscompares++; $display("FAIL r0_no_fwd: got %h/%h expected 0/0", obs_a[5], obs_b[5]);
    end
  endtask

  task automatic test_load_use();
    prog.delete();
    prog.push_back(mk(1, 5'd1, 5'd0, 5'd6, 1, 0, 1, 1, 1, 32'h4, 32'hCAFE0006));   // lw r6
    prog.push_back(mk(2, 5'd6, 5'd6, 5'd7, 1, 1, 1, 0, 0, 32'd0, 32'h7));          // add r7,r6,r6
    run_prog(-1, -1, 1'b0);
    vectors++;
`ifdef OPSTAGE_FWD_EN
    if (stall_cnt !== 1) begin miscompares++; $display("FAIL load_use_stalls: got %0d expected 1", stall_cnt); end
`else
    if (stall_cnt !== 3) begin miscompares++; $display("FAIL load_use_stalls: got %0d expected 3", stall_cnt); end
`endif
    vectors++;
    if (obs_stall[1] !== 1'b1) begin miscompares++; $display("FAIL load_use_stall_cyc1: got %b expected 1", obs_stall[1]); end
    vectors++;
    if (obs_a[2] !== 32'hCAFE0006 || obs_b[2] !== 32'hCAFE0006) begin
      miscompares++; $display("FAIL load_use_data: got %h/%h expected cafe0006", obs_a[2], obs_b[2]);
    end
  endtask

  task automatic test_flush_hazard();
    logic [31:0] r1v;
    r1v = arch[1];
    prog.delete();
    prog.push_back(mk(1, 5'd1, 5'd0, 5'd8, 1, 0, 1, 1, 1, 32'h8, 32'h0BAD0008));   // lw r8
    prog.push_back(mk(2, 5'd8, 5'd8, 5'd9, 1, 1, 1, 0, 0, 32'd0, 32'h9));          // squashed
    prog.push_back(mk(3, 5'd1, 5'd2, 5'd10, 1, 1, 1, 0, 0, 32'd0, 32'hA));
    run_prog(1, -1, 1'b0);
    vectors++;
    if (obs_stall[1] !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b expected 0", obs_stall[1]); end
    vectors++;
    if (seen[2] !== 1'b0) begin miscompares++; $display("FAIL flush_kill: got executed=%b expected 0", seen[2]); end
    vectors++;
    if (obs_a[3] !== r1v) begin miscompares++; $display("FAIL flush_next: got %h expected %h", obs_a[3], r1v); end
  endtask

  task automatic test_rst_during_stall();
    prog.delete();
    prog.push_back(mk(1, 5'd1, 5'd0, 5'd6, 1, 0, 1, 1, 1, 32'h4, 32'h600D0006));
    prog.push_back(mk(2, 5'd6, 5'd2, 5'd7, 1, 0, 1, 0, 1, 32'h1, 32'h7));
    run_prog(-1, 1, 1'b0);
    vectors++;
    if (obs_stall[1] !== 1'b0 || obs_exv[2] !== 1'b0) begin
      miscompares++; $display("FAIL rst_stall: got stall=%b next_ex_valid=%b expected 0/0", obs_stall[1], obs_exv[2]);
    end
`ifdef OPSTAGE_FWD_EN
    vectors++;
    if (obs_stall[2] !== 1'b0) begin miscompares++; $display("FAIL rst_stall_next: got %b expected 0", obs_stall[2]); end
`endif
    vectors++;
    if (obs_a[2] !== 32'h600D0006) begin miscompares++; $display("FAIL rst_resume_A: got %h expected 600d0006", obs_a[2]); end
  endtask

  task automatic test_back_to_back();
    prog.delete();
    prog.push_back(mk(1, 5'd1, 5'd2, 5'd11, 1, 1, 1, 0, 0, 32'd0, 32'h00005A5A));
    prog.push_back(mk(2, 5'd11, 5'd11, 5'd12, 1, 1, 1, 0, 0, 32'd0, 32'hC));
    run_prog(-1, -1, 1'b0);
    vectors++;
`ifdef OPSTAGE_FWD_EN
    if (stall_cnt !== 0) begin miscompares++; $display("FAIL b2b_stalls: got %0d expected 0", stall_cnt); end
`else
    if (stall_cnt !== 3) begin miscompares++; $display("FAIL b2b_stalls: got %0d expected 3", stall_cnt); end
`endif
    vectors++;
    if (obs_a[2] !== 32'h00005A5A) begin miscompares++; $display("FAIL b2b_A: got %h expected 00005a5a", obs_a[2]); end
  endtask

  task automatic test_random();
    bit mr, rw;
    prog.delete();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        prog.push_back(idle_slot());
      end else begin
        mr = ($urandom_range(0, 3) == 0);
        rw = mr || ($urandom_range(0, 3) != 0);
        prog.push_back(mk(100 + i, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), rw, mr,
                          mr ? 1'b1 : 1'($urandom), $urandom, $urandom));
      end
    end
    run_prog(-1, -1, 1'b1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_alu_src_imm = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_alu_op = '0; id_shamt = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    arch = rf;
    ex_s = bubble(); mem_s = bubble(); wb_s = bubble();

    test_reset();
    test_mem_forward();
    test_mem_beats_wb();
    test_load_use();
    test_flush_hazard();
    test_rst_during_stall();
    test_back_to_back();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
